// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit, one operand bit per cycle.
// Build option: define MULDIV_DIVIDE_EN to include the restoring divider (op 10/11).
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hiwrite,
  input  logic             lowrite,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   acch;
  logic [WIDTH-1:0]   accl;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   acch_nxt;
  logic [WIDTH-1:0]   accl_nxt;
  logic [2*WIDTH-1:0] fix_result;
`ifdef MULDIV_DIVIDE_EN
  logic               div_q;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
`endif

  function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate_dw(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  // Unsigned ops use the raw operand; the most-negative value maps onto itself as 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return (is_signed && (sv < 0)) ? negate_w(v, 1'b1) : v;
  endfunction

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Iteration step: {acch, accl} is the product shift register for multiply,
  // and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, acch} + (accl[0] ? {1'b0, opb} : '0);
    acch_nxt = mul_sum[WIDTH:1];
    accl_nxt = {mul_sum[0], accl[WIDTH-1:1]};
`ifdef MULDIV_DIVIDE_EN
    div_sh   = {acch, accl[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, opb});
    div_diff = div_sh - {1'b0, opb};
    if (div_q) begin
      acch_nxt = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      accl_nxt = {accl[WIDTH-2:0], div_ge};
    end
`endif
  end

  // Sign correction: a zero divisor falls out naturally as all-ones quotient and remainder = dividend.
  always_comb begin
    fix_result = negate_dw({acch, accl}, sign_a ^ sign_b);
`ifdef MULDIV_DIVIDE_EN
    if (div_q) begin
      fix_result[WIDTH-1:0]       = negate_w(accl, sign_a ^ sign_b);
      fix_result[2*WIDTH-1:WIDTH] = negate_w(acch, sign_a);
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acch   <= '0;
      accl   <= '0;
      opb    <= '0;
      hi     <= '0;
      lo     <= '0;
`ifdef MULDIV_DIVIDE_EN
      div_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (hiwrite) hi <= wd;
          if (lowrite) lo <= wd;
          if (start) begin
            sign_a <= ~op[0] & srca[WIDTH-1];
            sign_b <= ~op[0] & srcb[WIDTH-1];
            acch   <= '0;
            accl   <= magnitude(srca, ~op[0]);
            opb    <= magnitude(srcb, ~op[0]);
            cnt    <= CNT_W'(WIDTH-1);
`ifdef MULDIV_DIVIDE_EN
            div_q  <= op[1];
            state  <= ITER;
`else
            state  <= op[1] ? DONE : ITER;
`endif
          end
        end
        ITER: begin
          acch <= acch_nxt;
          accl <= accl_nxt;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          {hi, lo} <= fix_result;
          state    <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand width and the width of each HI/LO register (legal range 4..64).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 SHALL have port srca  input  WIDTH  multiplicand or dividend (rs).
REQ-007 SHALL have port srcb  input  WIDTH  multiplier or divisor (rt).
REQ-008 SHALL have port hiwrite  input  1  MTHI strobe; loads wd into HI.
REQ-009 SHALL have port lowrite  input  1  MTLO strobe; loads wd into LO.
REQ-010 SHALL have port wd  input  WIDTH  write data for MTHI/MTLO.
REQ-011 SHALL have port busy  output  1  high while an operation is in progress; the controller stalls MFHI/MFLO on it.
REQ-012 SHALL have port done  output  1  one-cycle pulse marking result valid.
REQ-013 SHALL have port hi  output  WIDTH  HI register (product upper half or remainder).
REQ-014 SHALL have port lo  output  WIDTH  LO register (product lower half or quotient).

Function
REQ-015 SHALL implement FSM states IDLE, ITER, FIX, DONE; busy = (state != IDLE).
REQ-016 SHALL in IDLE with start=1 latch op, srca and srcb, load the iteration counter with WIDTH-1, and go to ITER at the next edge.
REQ-017 SHALL in ITER process one bit per cycle: shift-add for multiply, restoring shift-subtract for divide, both on operand magnitudes; decrement the counter each cycle; go to FIX when the counter reaches 0 (exactly WIDTH ITER cycles).
REQ-018 SHALL in FIX apply sign correction for signed ops: product negated (2*WIDTH bits) if the operand signs differ; quotient negated if the signs differ; remainder takes the sign of the dividend. Unsigned ops pass through unchanged. Next state is DONE.
REQ-019 SHALL in DONE load hi/lo with the result, assert done for that single cycle, and return to IDLE.
REQ-020 SHALL make hi/lo valid in the done cycle, with latency from start-sampling edge to done cycle = WIDTH+2 cycles.
REQ-021 SHALL ignore start while busy=1; the in-flight operation completes unaffected.
REQ-022 SHALL on divide by zero produce, for DIVU, hi=srca and lo=all-ones; for DIV, hi=srca and lo=all-ones if srca>=0, else lo=1.
REQ-023 SHALL on DIV of most-negative by -1 produce lo=most-negative (wrap) and hi=0.
REQ-024 SHALL in IDLE load HI from wd when hiwrite=1 and LO from wd when lowrite=1 at the next edge; both may occur in the same cycle.
REQ-025 SHALL ignore hiwrite/lowrite while busy=1.
REQ-026 SHALL, when start and hiwrite/lowrite coincide in IDLE, perform both; the later DONE load overwrites hi/lo.
REQ-027 SHALL hold hi/lo stable in all states except DONE, and in IDLE when written via REQ-024.

Reset
REQ-028 SHALL on reset force state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, and clear internal operand/accumulator registers.
REQ-029 SHALL abort any in-flight operation on reset mid-operation without producing done; the first start after reset release behaves normally.

Configuration
REQ-030 SHALL, when macro MULDIV_DIVIDE_EN is defined, include the divider datapath and support op 10/11 per REQ-017..REQ-023.
REQ-031 SHALL, when MULDIV_DIVIDE_EN is undefined, omit the divider; op 10/11 with start then go IDLE->DONE directly: done pulses at the second edge after sampling, busy is high for that one cycle, and hi/lo are left unchanged. Multiply behaviour is identical in both builds.

Verification (WIDTH=32)
REQ-032 SHALL cover: MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 34 cycles after start sampled, single-cycle pulse.
REQ-033 SHALL cover: MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 SHALL cover: DIVU 100/0 -> hi=0x00000064, lo=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
REQ-035 SHALL cover: second start with different operands at cycle 5 of a MULTU -> ignored, first result intact; hiwrite wd=0x1234 while busy -> hi unchanged.
REQ-036 SHALL cover: reset asserted at ITER cycle 10 -> hi=lo=0, busy=0 immediately, no done; following MULTU 6*7 -> lo=0x2A, hi=0.
REQ-037 SHALL cover: with MULTU 6*7 run in both builds -> lo=0x2A, hi=0 with identical timing; without MULDIV_DIVIDE_EN, DIVU 9/3 -> done at 2nd edge after sampling, hi/lo unchanged.
